gate_circuit_tester: RTL and testbench

//  Programmable, registered successor to the fixed 4-input gate circuit.
//  - Holds each output function as a truth table of 2^N_IN rows x N_OUT bits.
//  - Live mode: evaluates a user input vector.
//  - Sweep mode: self-tests by walking all input rows, folding outputs into a MISR

---
 rtl/gate_circuit_pkg.sv | 45 ++++
 rtl/gate_circuit_tester_tt_mem.sv | 33 +++
 rtl/gate_circuit_tester.sv | 96 +++++++++
 tb/tb_gate_circuit_tester.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_circuit_pkg.sv
// Shared types and helpers for the programmable gate circuit tester.
// Holds the FSM states, MISR defaults, reset truth table and MISR step.
package gate_circuit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK
  } state_t;

  localparam logic [15:0] POLY_DEF = 16'h1021;
  localparam logic [15:0] SEED_DEF = 16'hFFFF;

  // Reset contents of one row; only the 4x4 build has a real circuit.
  function automatic logic [31:0] init_row(
    input int n_in,
    input int n_out,
    input int row
  );
    logic a, b, c, d;
    if (n_in != 4 || n_out != 4) return '0;
    a = row[3];
    b = row[2];
    c = row[1];
    d = row[0];
    return {28'd0, a,
            (~a & b) | (a & ~b & d),
            (~a & c) | (c & ~d) | (a & ~c & d),
            d};
  endfunction

  function automatic logic [31:0] misr_step(
    input logic [31:0] sig,
    input logic [31:0] data,
    input logic [31:0] poly,
    input int          w
  );
    logic [31:0] mask;
    logic [31:0] fb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = (((sig >> (w - 1)) & 32'd1) != 32'd0) ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/gate_circuit_tester_tt_mem.sv
// Truth-table register array: async-reset init, one write port,
// one combinational read port (reads see the pre-write value).
module gate_tt_mem
  import gate_circuit_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata
);

  localparam int DEPTH = 1 << N_IN;

  logic [N_OUT-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= N_OUT'(init_row(N_IN, N_OUT, i));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gate_circuit_tester.sv
// Programmable registered gate circuit with a MISR-based
// self-test sweep over every truth-table row.
module gate_circuit_tester
  import gate_circuit_pkg::*;
#(
  parameter int               N_IN  = 4,
  parameter int               N_OUT = 4,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iMode,
  input  logic [N_IN-1:0]  iIn,
  input  logic             iCfgWe,
  input  logic [N_IN-1:0]  iCfgAddr,
  input  logic [N_OUT-1:0] iCfgData,
  input  logic             iStart,
  input  logic [SIG_W-1:0] iExpSig,
  output logic [N_OUT-1:0] oOut,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [SIG_W-1:0] oSig
);

  localparam logic [N_IN-1:0] LAST = '1;

  state_t           state;
  logic [N_IN-1:0]  idx;
  logic [N_IN-1:0]  raddr;
  logic [N_OUT-1:0] rdata;
  logic             we;
  logic [SIG_W-1:0] sig_next;

  // The table is frozen while a sweep owns it.
  assign we    = iCfgWe && (state == IDLE);
  assign raddr = (state == RUN) ? idx : iIn;

  assign sig_next = SIG_W'(misr_step(32'(oSig), 32'(rdata),
                                     32'(POLY), SIG_W));

  gate_tt_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_mem (
    .clk   (iClk),
    .rst_n (iRst_n),
    .we    (we),
    .waddr (iCfgAddr),
    .wdata (iCfgData),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      idx   <= '0;
      oOut  <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oPass <= 1'b0;
      oSig  <= SEED;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE: begin
          oOut <= rdata;
          if (iStart && iMode) begin
            state <= RUN;
            idx   <= '0;
            oSig  <= SEED;
            oPass <= 1'b0;
            oBusy <= 1'b1;
          end
        end
        RUN: begin
          oOut <= rdata;
          oSig <= sig_next;
          idx  <= idx + 1'b1;
          if (idx == LAST) state <= CHECK;
        end
        CHECK: begin
          oPass <= (oSig == iExpSig);
          oBusy <= 1'b0;
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_circuit_tester.sv
// Directed bench for gate_circuit_tester: live table, config writes,
// sweeps, mid-sweep abort and a small 3-in/2-out build.
module tb_gate_circuit_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mode;
  logic [3:0]  in_v;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        start;
  logic [15:0] exp_sig;
  logic [3:0]  out_v;
  logic        busy, done, pass;
  logic [15:0] sig;

  logic        rst2_n;
  logic        mode2;
  logic [2:0]  in2;
  logic        we2;
  logic [2:0]  addr2;
  logic [1:0]  data2;
  logic        start2;
  logic [7:0]  exp2;
  logic [1:0]  out2;
  logic        busy2, done2, pass2;
  logic [7:0]  sig2;

  gate_circuit_tester dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iMode    (mode),
    .iIn      (in_v),
    .iCfgWe   (cfg_we),
    .iCfgAddr (cfg_addr),
    .iCfgData (cfg_data),
    .iStart   (start),
    .iExpSig  (exp_sig),
    .oOut     (out_v),
    .oBusy    (busy),
    .oDone    (done),
    .oPass    (pass),
    .oSig     (sig)
  );

  gate_circuit_tester #(
    .N_IN  (3),
    .N_OUT (2),
    .SIG_W (8),
    .POLY  (8'h1D),
    .SEED  (8'hFF)
  ) dut2 (
    .iClk     (clk),
    .iRst_n   (rst2_n),
    .iMode    (mode2),
    .iIn      (in2),
    .iCfgWe   (we2),
    .iCfgAddr (addr2),
    .iCfgData (data2),
    .iStart   (start2),
    .iExpSig  (exp2),
    .oOut     (out2),
    .oBusy    (busy2),
    .oDone    (done2),
    .oPass    (pass2),
    .oSig     (sig2)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Hand-derived reset table, row index = {A,B,C,D}.
  logic [3:0] tt_m [16];
  logic [3:0] tt2_m [16];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_sig(
    input int          w,
    input int          rows,
    input logic [31:0] poly,
    input logic [31:0] seed,
    input logic [3:0]  tt [16]
  );
    logic [31:0] s, mask;
    logic        msb;
    mask = (32'd1 << w) - 32'd1;
    s = seed;
    for (int i = 0; i < rows; i++) begin
      msb = s[w-1];
      s = ((s << 1) ^ (msb ? poly : 32'd0) ^ {28'd0, tt[i]}) & mask;
    end
    return s;
  endfunction

  task automatic do_reset;
    rst_n = 0; rst2_n = 0;
    mode = 0; in_v = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; exp_sig = 0;
    mode2 = 0; in2 = 0; we2 = 0; addr2 = 0; data2 = 0;
    start2 = 0; exp2 = 0;
    tick;
    tick;
    rst_n = 1; rst2_n = 1;
    tt_m = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
             4'h8, 4'hF, 4'hA, 4'hD, 4'h8, 4'hB, 4'hA, 4'h9};
  endtask

  task automatic run_sweep(input logic [15:0] exp, input int inj,
                           output int nbusy, output bit seen);
    mode = 1; exp_sig = exp; start = 1;
    tick;
    start = 0;
    nbusy = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nbusy++;
      if (done) begin
        seen = 1;
        break;
      end
      if (k == inj) begin
        start = 1; cfg_we = 1; cfg_addr = 0; cfg_data = 4'hF;
      end
      tick;
      start = 0; cfg_we = 0;
    end
  endtask

  initial begin
    logic [15:0] m;
    int nb;
    bit seen;
    int ndone;

    do_reset;
    check("rst_out", out_v, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", sig, 16'hFFFF);

    // Live evaluation of every row
    in_v = 4'b1011; tick;
    check("live_1011", out_v, 4'b1101);
    in_v = 4'b0110; tick;
    check("live_0110", out_v, 4'b0110);
    for (int r = 0; r < 16; r++) begin
      in_v = 4'(r); tick;
      check($sformatf("live_row%0d", r), out_v, tt_m[r]);
    end

    // Read-before-write on the same row
    do_reset;
    in_v = 4'hF; tick;
    check("rbw_before", out_v, 4'b1001);
    cfg_we = 1; cfg_addr = 4'hF; cfg_data = 4'h0; tick;
    cfg_we = 0;
    check("rbw_same", out_v, 4'b1001);
    tick;
    check("rbw_next", out_v, 4'b0000);

    // Sweep with the correct expected signature
    do_reset;
    m = 16'(model_sig(16, 16, 32'h1021, 32'hFFFF, tt_m));
    run_sweep(m, -1, nb, seen);
    check("sw_busy", nb, 17);
    check("sw_done", seen, 1);
    check("sw_busy_at_done", busy, 0);
    check("sw_pass", pass, 1);
    check("sw_sig", sig, m);
    tick;
    check("sw_done_pulse", done, 0);
    check("sw_pass_hold", pass, 1);

    run_sweep(m ^ 16'd1, -1, nb, seen);
    check("swb_done", seen, 1);
    check("swb_pass", pass, 0);
    check("swb_sig", sig, m);

    // Restart and config write during RUN are ignored
    run_sweep(m, 3, nb, seen);
    check("inj_busy", nb, 17);
    check("inj_pass", pass, 1);
    check("inj_sig", sig, m);
    mode = 0; in_v = 4'h0; tick;
    check("inj_row0", out_v, 4'h0);
    tick;
    check("inj_idle", busy, 0);

    // Reset at RUN row 5
    mode = 1; start = 1; tick;
    start = 0;
    repeat (5) tick;
    check("ab_busy_pre", busy, 1);
    rst_n = 0; #1;
    check("ab_out", out_v, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_pass", pass, 0);
    check("ab_sig", sig, 16'hFFFF);
    tick;
    rst_n = 1;
    mode = 0; in_v = 4'hF;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done) ndone++;
    end
    check("ab_nodone", ndone, 0);
    check("ab_row15", out_v, 4'b1001);

    // Small build: zero table, then a written table swept
    for (int r = 0; r < 8; r++) begin
      in2 = 3'(r); tick;
      check($sformatf("s_init%0d", r), out2, 0);
    end
    tt2_m = '{default: 4'h0};
    for (int r = 0; r < 8; r++) begin
      tt2_m[r] = 4'((r * 3 + 1) & 3);
      we2 = 1; addr2 = 3'(r); data2 = 2'(tt2_m[r]); tick;
    end
    we2 = 0;
    m = 16'(model_sig(8, 8, 32'h1D, 32'hFF, tt2_m));
    mode2 = 1; exp2 = m[7:0]; start2 = 1; tick;
    start2 = 0;
    nb = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy2) nb++;
      if (done2) begin
        seen = 1;
        break;
      end
      tick;
    end
    check("s_busy", nb, 9);
    check("s_done", seen, 1);
    check("s_pass", pass2, 1);
    check("s_sig", sig2, m[7:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
